// File: rtl/cmd_deframer_if.sv
// Byte-stream input and per-channel command output bundle for cmd_deframer.
interface cmd_deframer_if #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned NCH    = 4
);
  logic [7:0]          Q;
  logic                nRx;
  logic [8*NBYTES-1:0] cmd_data;
  logic [NCH-1:0]      cmd_valid;
  logic [NCH-1:0]      cmd_ready;
  logic                busy;
  logic                chk_err;
  logic                ch_err;
  logic                tmo_err;
  logic                drop_err;

  // Byte source and command consumer side.
  modport master (
    output Q, nRx, cmd_ready,
    input  cmd_data, cmd_valid, busy, chk_err, ch_err, tmo_err, drop_err
  );

  // Deframer side.
  modport slave (
    input  Q, nRx, cmd_ready,
    output cmd_data, cmd_valid, busy, chk_err, ch_err, tmo_err, drop_err
  );
endinterface

// File: rtl/cmd_deframer.sv
// Command deframer: HEADER, CH, NBYTES payload, XOR checksum -> one-hot
// per-channel command with valid/ready handshake and single-cycle error pulses.
module cmd_deframer #(
  parameter int unsigned NBYTES  = 4,
  parameter int unsigned NCH     = 4,
  parameter logic [7:0]  HEADER  = 8'hF0,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          nRst,
  cmd_deframer_if.slave bus
);

  localparam int unsigned PW  = 8 * NBYTES;
  localparam int unsigned CW  = $clog2(NBYTES + 1);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned TW  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHAN,
    S_PAYLOAD,
    S_CHECK,
    S_OUT
  } state_e;

  state_e          state_q, state_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      xor_q, xor_d;
  logic [PW-1:0]   pay_q, pay_d;
  logic [TW-1:0]   idle_q, idle_d;

  logic [PW-1:0]   data_q, data_d;
  logic [NCH-1:0]  valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            chk_err_q, chk_err_d;
  logic            ch_err_q, ch_err_d;
  logic            tmo_err_q, tmo_err_d;
  logic            drop_err_q, drop_err_d;

  logic            rx_c;
  logic            ch_bad_c;
  logic            chk_ok_c;
  logic            tmo_hit_c;
  logic            in_frame_c;
  logic            last_byte_c;
  logic            ready_sel_c;
  logic [NCH-1:0]  ch_onehot_c;

  assign rx_c        = !bus.nRx;
  assign ch_bad_c    = 32'(bus.Q) >= NCH;
  assign chk_ok_c    = (bus.Q == xor_q);
  assign tmo_hit_c   = (idle_q == TW'(TIMEOUT - 1));
  assign in_frame_c  = (state_q == S_CHAN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
  assign last_byte_c = (cnt_q == CW'(NBYTES - 1));
  assign ch_onehot_c = NCH'(1) << ch_q;
  // Only the addressed channel's ready can retire the command.
  assign ready_sel_c = |(bus.cmd_ready & ch_onehot_c);

  // State, datapath and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      cnt_q      <= '0;
      xor_q      <= '0;
      pay_q      <= '0;
      idle_q     <= '0;
      data_q     <= '0;
      valid_q    <= '0;
      busy_q     <= 1'b0;
      chk_err_q  <= 1'b0;
      ch_err_q   <= 1'b0;
      tmo_err_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      xor_q      <= xor_d;
      pay_q      <= pay_d;
      idle_q     <= idle_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      chk_err_q  <= chk_err_d;
      ch_err_q   <= ch_err_d;
      tmo_err_q  <= tmo_err_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Next state and frame datapath; an accepted byte always beats the timeout.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    pay_d   = pay_q;
    idle_d  = '0;
    if (in_frame_c && !rx_c) begin
      if (tmo_hit_c) begin
        state_d = S_IDLE;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_c && (bus.Q == HEADER)) begin
            state_d = S_CHAN;
          end
        end
        S_CHAN: begin
          if (ch_bad_c) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_PAYLOAD;
            ch_d    = CHW'(bus.Q);
            cnt_d   = '0;
            xor_d   = bus.Q;
          end
        end
        S_PAYLOAD: begin
          pay_d = (pay_q << 8) | PW'(bus.Q);
          xor_d = xor_q ^ bus.Q;
          if (last_byte_c) begin
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_CHECK: begin
          state_d = chk_ok_c ? S_OUT : S_IDLE;
        end
        S_OUT: begin
          if (ready_sel_c) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Next values of the registered outputs; each error belongs to one state.
  always_comb begin
    data_d     = data_q;
    valid_d    = '0;
    busy_d     = (state_d != S_IDLE);
    chk_err_d  = 1'b0;
    ch_err_d   = 1'b0;
    tmo_err_d  = 1'b0;
    drop_err_d = 1'b0;
    if (state_d == S_OUT) begin
      valid_d = ch_onehot_c;
    end
    if ((state_q == S_CHECK) && rx_c && chk_ok_c) begin
      data_d = pay_q;
    end
    case (state_q)
      S_CHAN:  ch_err_d   = rx_c && ch_bad_c;
      S_CHECK: chk_err_d  = rx_c && !chk_ok_c;
      S_OUT:   drop_err_d = rx_c;
      default: ;
    endcase
    tmo_err_d = in_frame_c && !rx_c && tmo_hit_c;
  end

  assign bus.cmd_data  = data_q;
  assign bus.cmd_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.chk_err   = chk_err_q;
  assign bus.ch_err    = ch_err_q;
  assign bus.tmo_err   = tmo_err_q;
  assign bus.drop_err  = drop_err_q;

endmodule
